// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 6;

    localparam int unsigned DEFAULT_DIV_LAT  = 34;
    localparam int unsigned DEFAULT_MULT_LAT = 33;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULT = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
    localparam logic [OP_W-1:0] OP_MTHI = 3'd3;
    localparam logic [OP_W-1:0] OP_MTLO = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_DIV  = 2'd1,
        RUN_MULT = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_lat_counter.sv
// Latency counter shared by the divide and multiply runs; flags when cnt reaches lat.
module muldiv_lat_counter
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lat,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt;

    // Clear on accept, count while a core is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == lat);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences the external multiply/divide cores and owns the HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned DIV_LAT  = DEFAULT_DIV_LAT,
    parameter int unsigned MULT_LAT = DEFAULT_MULT_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        mult_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [31:0] div_high,
    input  logic [31:0] div_low,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo
);

    muldiv_state_t     state_q, state_d;
    logic [DATA_W-1:0] hi_d, lo_d;
    logic [DATA_W-1:0] div_a_d, div_b_d, mult_a_d, mult_b_d;
    logic              done_d, div0_d, div_start_d, mult_start_d;
    logic              cnt_clr, cnt_en, tc_c;
    logic [CNT_W-1:0]  lat_c;

    // Terminal count depends on which core is running.
    assign lat_c = (state_q == RUN_MULT) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);

    muldiv_lat_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .lat  (lat_c),
        .tc_c (tc_c)
    );

    assign busy = (state_q != IDLE);

    // Next-state and next-output decode; flush outranks accept and completion.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi;
        lo_d         = lo;
        div_a_d      = div_a;
        div_b_d      = div_b;
        mult_a_d     = mult_a;
        mult_b_d     = mult_b;
        done_d       = 1'b0;
        div0_d       = 1'b0;
        div_start_d  = 1'b0;
        mult_start_d = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    case (op)
                        OP_MULT: begin
                            mult_a_d     = rs_val;
                            mult_b_d     = rt_val;
                            mult_start_d = 1'b1;
                            cnt_clr      = 1'b1;
                            state_d      = RUN_MULT;
                        end
                        OP_DIV: begin
                            if (rt_val == '0) begin
                                div0_d = 1'b1;
                            end else begin
                                div_a_d     = rs_val;
                                div_b_d     = rt_val;
                                div_start_d = 1'b1;
                                cnt_clr     = 1'b1;
                                state_d     = RUN_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = rs_val;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = rs_val;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN_DIV, RUN_MULT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (tc_c) begin
                        hi_d    = (state_q == RUN_DIV) ? div_high : mult_hi;
                        lo_d    = (state_q == RUN_DIV) ? div_low  : mult_lo;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi         <= '0;
            lo         <= '0;
            div_a      <= '0;
            div_b      <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            done       <= 1'b0;
            div0_exc   <= 1'b0;
            div_start  <= 1'b0;
            mult_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi         <= hi_d;
            lo         <= lo_d;
            div_a      <= div_a_d;
            div_b      <= div_b_d;
            mult_a     <= mult_a_d;
            mult_b     <= mult_b_d;
            done       <= done_d;
            div0_exc   <= div0_d;
            div_start  <= div_start_d;
            mult_start <= mult_start_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural core models and a result scoreboard.
module tb_muldiv_ctrl;

    localparam int unsigned DIV_LAT  = 34;
    localparam int unsigned MULT_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        busy, done, div0_exc, div_start, mult_start;
    logic [31:0] hi, lo, div_a, div_b, mult_a, mult_b;
    logic [31:0] div_high, div_low, mult_hi, mult_lo;

    muldiv_ctrl #(.DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .done(done), .div0_exc(div0_exc),
        .hi(hi), .lo(lo), .div_start(div_start), .mult_start(mult_start),
        .div_a(div_a), .div_b(div_b), .mult_a(mult_a), .mult_b(mult_b),
        .div_high(div_high), .div_low(div_low), .mult_hi(mult_hi), .mult_lo(mult_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider core model: result valid DIV_LAT cycles after the start cycle.
    logic [31:0] dq = '0, dr = '0;
    int          dcnt = 0;
    logic        dpend = 1'b0;
    always @(posedge clk) begin
        if (div_start) begin
            dq    <= (div_b != 0) ? div_a / div_b : 32'hFFFF_FFFF;
            dr    <= (div_b != 0) ? div_a % div_b : div_a;
            dcnt  <= DIV_LAT - 1;
            dpend <= 1'b1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign div_low  = (dpend && dcnt == 0) ? dq : 32'hBAD0_0BAD;
    assign div_high = (dpend && dcnt == 0) ? dr : 32'hBAD1_1BAD;

    // Multiplier core model: result valid MULT_LAT cycles after the start cycle.
    logic [63:0] mp = '0;
    int          mcnt = 0;
    logic        mpend = 1'b0;
    always @(posedge clk) begin
        if (mult_start) begin
            mp    <= 64'(mult_a) * 64'(mult_b);
            mcnt  <= MULT_LAT - 1;
            mpend <= 1'b1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mult_lo = (mpend && mcnt == 0) ? mp[31:0]  : 32'hBAD2_2BAD;
    assign mult_hi = (mpend && mcnt == 0) ? mp[63:32] : 32'hBAD3_3BAD;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_hi = '0, m_lo = '0;

    // Expect a done with the given HI/LO at an absolute cycle.
    task automatic expect_done(input logic [31:0] h, input logic [31:0] l, input int at);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = at;
        m_hi = h; m_lo = l;
        sb.push_back(e);
    endtask

    // Scoreboard: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hi", hi, e.hi);
                check("sb_lo", lo, e.lo);
                check("sb_cyc", cyc, e.cyc);
                check("sb_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    endtask

    task automatic idle_in();
        op_valid = 1'b0; op = 3'd0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (done) return;
        end
        check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        bit seen;

        // Reset
        step(); step();
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div0", 32'(div0_exc), 32'd0);
        check("rst_starts", {30'd0, div_start, mult_start}, 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_mult_b", mult_b, 32'd0);
        rst = 1'b0;
        step();

        // DIV 100 / 7
        c0 = cyc;
        drive(3'd2, 32'd100, 32'd7);
        expect_done(32'd2, 32'd14, c0 + 36);
        step(); idle_in();
        check("div_start_c1", 32'(div_start), 32'd1);
        check("div_busy_c1", 32'(busy), 32'd1);
        check("div_a", div_a, 32'd100);
        check("div_b", div_b, 32'd7);
        for (int k = 2; k <= 35; k++) begin
            step();
            check("div_busy_run", 32'(busy), 32'd1);
            check("div_start_run", 32'(div_start), 32'd0);
        end
        step();
        check("div_done_c36", 32'(done), 32'd1);
        check("div_lo_c36", lo, 32'd14);
        check("div_hi_c36", hi, 32'd2);

        // MTHI then MULT 3 x 5
        c0 = cyc;
        drive(3'd3, 32'hDEAD_BEEF, 32'd0);
        expect_done(32'hDEAD_BEEF, m_lo, c0 + 1);
        step(); idle_in();
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_done", 32'(done), 32'd1);
        check("mthi_busy", 32'(busy), 32'd0);
        c0 = cyc;
        drive(3'd1, 32'd3, 32'd5);
        expect_done(32'd0, 32'd15, c0 + MULT_LAT + 2);
        step(); idle_in();
        check("mult_start_c1", 32'(mult_start), 32'd1);
        wait_done(MULT_LAT + 5);

        // DIV by zero with HI/LO = 1/2
        step();
        c0 = cyc;
        drive(3'd3, 32'd1, 32'd0);
        expect_done(32'd1, m_lo, c0 + 1);
        step();
        drive(3'd4, 32'd2, 32'd0);
        expect_done(32'd1, 32'd2, c0 + 2);
        step();
        drive(3'd2, 32'd55, 32'd0);
        step(); idle_in();
        check("div0_exc_c1", 32'(div0_exc), 32'd1);
        check("div0_done", 32'(done), 32'd0);
        check("div0_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (div_start) seen = 1'b1;
            step();
        end
        check("div0_no_start", 32'(seen), 32'd0);
        check("div0_exc_pulse", 32'(div0_exc), 32'd0);
        check("div0_hi", hi, 32'd1);
        check("div0_lo", lo, 32'd2);

        // MULT 6 x 7 with a DIV 50 / 5 held pending
        c0 = cyc;
        drive(3'd1, 32'd6, 32'd7);
        expect_done(32'd0, 32'd42, c0 + MULT_LAT + 2);
        step();
        drive(3'd2, 32'd50, 32'd5);
        seen = 1'b0;
        for (int k = 0; k < MULT_LAT + 5; k++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("hold_no_div_start", 32'(div_start), 32'd0);
        end
        check("hold_done_seen", 32'(seen), 32'd1);
        expect_done(32'd0, 32'd10, cyc + 36);
        step(); idle_in();
        check("hold_div_start", 32'(div_start), 32'd1);
        check("hold_div_busy", 32'(busy), 32'd1);
        wait_done(40);

        // Flush in IDLE blocks acceptance
        step();
        drive(3'd4, 32'h55, 32'd0);
        flush = 1'b1;
        step(); idle_in(); flush = 1'b0;
        check("idle_flush_lo", lo, m_lo);
        check("idle_flush_done", 32'(done), 32'd0);

        // DIV flushed in cycle 10
        drive(3'd2, 32'd1000, 32'd10);
        step(); idle_in();
        for (int k = 2; k <= 10; k++) step();
        check("flush_busy_c10", 32'(busy), 32'd1);
        flush = 1'b1;
        step(); flush = 1'b0;
        check("flush_busy_c11", 32'(busy), 32'd0);
        check("flush_hi", hi, m_hi);
        check("flush_lo", lo, m_lo);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen = 1'b1;
            step();
        end
        check("flush_no_done", 32'(seen), 32'd0);

        // Reset in cycle 20 of a MULT
        drive(3'd1, 32'd9, 32'd9);
        step(); idle_in();
        for (int k = 2; k <= 20; k++) step();
        rst = 1'b1;
        step();
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("mrst_no_done", 32'(seen), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Controller that sequences the processor's multi-cycle multiply and divide cores and owns the architectural HI/LO registers. It accepts MULT, DIV, MTHI and MTLO operations from the multicycle control unit, drives each core's start pulse with operands held stable, and counts the fixed core latency. It captures results into HI/LO and raises `busy` so the control FSM stalls on MFHI/MFLO and on new mult/div ops. Divide-by-zero is detected here and reported as a one-cycle exception pulse.

## Interface
Parameters:
- DIV_LAT, 34, cycles from `div_start` high to stable `div_high`/`div_low`.
- MULT_LAT, 33, cycles from `mult_start` high to stable `mult_hi`/`mult_lo`.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request, sampled each cycle.
- op  in  3  0=NOP, 1=MULT, 2=DIV, 3=MTHI, 4=MTLO; 5–7 treated as NOP.
- rs_val  in  32  dividend/multiplicand, or MTHI/MTLO data.
- rt_val  in  32  divisor/multiplier.
- flush  in  1  abort in-flight operation (exception/branch flush).
- busy  out  1  operation in flight; new ops are not accepted.
- done  out  1  one-cycle pulse: operation completed and HI/LO updated.
- div0_exc  out  1  one-cycle pulse: DIV with `rt_val` == 0.
- hi, lo  out  32  architectural HI/LO registers.
- div_start, mult_start  out  1  one-cycle start pulses to the cores.
- div_a, div_b, mult_a, mult_b  out  32  operand registers, stable while running.
- div_high, div_low, mult_hi, mult_lo  in  32  core results.

## Operation
- States: IDLE, RUN_DIV, RUN_MULT.
- Accept condition: `op_valid` && state == IDLE && !`flush`, evaluated at a rising edge. When not accepted, `op_valid` is ignored. The requester holds the request; `busy` serves as the stall.
- MULT accept: latch `rs_val`/`rt_val` into `mult_a`/`mult_b`, clear `cnt`, go to RUN_MULT.
- DIV accept, `rt_val` != 0: latch into `div_a`/`div_b`, clear `cnt`, go to RUN_DIV.
- DIV accept, `rt_val` == 0: stay IDLE, do not start the core, leave HI/LO unchanged. `div0_exc` is high for the next cycle; `done` stays low.
- MTHI/MTLO accept: write `rs_val` into `hi`/`lo` at the accept edge; `done` is high for the next cycle; `busy` is never raised.
- RUN_x: `cnt` (6 bits) increments every cycle. The start pulse is high only when `cnt` == 0. At the edge where `cnt` == LAT, capture `hi` := core high word and `lo` := core low word, then return to IDLE. `done` is high for the following cycle.
- Results pass through unmodified. Sign fix-up belongs to the cores.
- `flush` in RUN_x: return to IDLE at that edge. HI/LO keep their old values, no `done`, start outputs low. Late core results are ignored.
- `flush` in IDLE: blocks acceptance for that cycle and has no other effect.
- Operand registers hold their last values in IDLE.

## Timing
- Reset (at edge with `rst`=1, from any state): state=IDLE, `cnt`=0, `hi`=`lo`=0, operand registers=0. `busy`, `done`, `div0_exc`, `div_start` and `mult_start` are all 0.
- Accept at edge E0 (cycle 0). Start pulse in cycle 1. `busy` is high in cycles 1..LAT+1.
- HI/LO update at the edge ending cycle LAT+1.
- Cycle LAT+2: `done`=1, `busy`=0, new HI/LO visible. A new op can be accepted at the end of this cycle.
- Total DIV latency with the default parameter: 36 cycles from accept to the `done` cycle.
- `busy` = (state != IDLE), decoded from registered state. `done` and `div0_exc` are registered.
- MTHI/MTLO: new value visible in cycle 1. `done` is high in cycle 1.
- `rst` has priority over `flush`; `flush` has priority over accept and completion. If `flush` and `cnt` == LAT occur together, the flush wins: no capture.

## Structure
- Package `muldiv_pkg`:
  - op encodings OP_NOP/OP_MULT/OP_DIV/OP_MTHI/OP_MTLO;
  - state enum `muldiv_state_t`;
  - default latency constants.
- The cores are external; the controller is a single module with no required sub-modules.
- A small `muldiv_lat_counter` (clear, enable, terminal-count compare) is a natural sub-module if it is shared.

## Test plan
- Reset, then DIV with `rs_val`=100, `rt_val`=7, using a behavioural divider model (results valid at DIV_LAT). Required: `div_start` high only in cycle 1 and `busy` high in cycles 1–35. In cycle 36, `done`=1, `lo`=14 and `hi`=2.
- MTHI 0xDEADBEEF, then MULT 3×5 (core model returns hi=0, lo=15). Required: `hi`=0xDEADBEEF and `done` in cycle 1. After the MULT, `hi`=0, `lo`=15 and `done` occur in cycle MULT_LAT+2.
- DIV with `rt_val`=0 while HI/LO = 1/2. Required: `div0_exc`=1 in cycle 1 and `done`=0. `div_start` never rises and HI/LO stay 1/2.
- MULT accepted, then a DIV request held high while `busy`. Required: the DIV is accepted only in the `done` cycle, and `div_start` fires exactly one cycle later.
- DIV in flight with `flush` asserted in cycle 10. Required: `busy`=0 from cycle 11 with HI/LO unchanged. No `done` appears even after the core finishes.
- `rst` asserted in cycle 20 of a MULT. Required: next cycle `hi`=`lo`=0, `busy`=0, `done`=0, and no later `done`.
